// File: rtl/tsp_disp_pkg.sv
// Shared constants and state type for the performance display controller.
package tsp_disp_pkg;
  localparam int NUM_DIGITS = 6;
  localparam int BIN_W      = 20;
  localparam int BCD_W      = 24;
  localparam logic [31:0] MAX_DISP = 32'd999999;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} disp_state_t;
endpackage

// File: rtl/perf_display_ctrl_bcd_add3.sv
// Double-dabble digit adjuster: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/perf_display_ctrl.sv
// Samples perf on a refresh tick or request and converts it to six BCD digits, one shift per clock.
// Define PERF_DISP_LZ_BLANK_EN to blank leading zero digits.
//
// state | meaning
// IDLE  | waiting for tick, req or a pending request
// SHIFT | 20 double-dabble shift cycles
// DONE  | publish digits/blank/ovf and pulse upd
module perf_display_ctrl #(
  parameter int REFRESH_LOG2 = 25,
  parameter int NUM_DIGITS   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             perf,
  input  logic                    req,
  input  logic                    freeze,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    ovf,
  output logic                    busy,
  output logic                    upd
);
  import tsp_disp_pkg::*;

  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_DISP);

  disp_state_t              state;
  logic [REFRESH_LOG2-1:0]  cnt;
  logic                     tick;
  logic                     start;
  logic                     pending;
  logic                     ovf_next;
  logic [4:0]               sh_cnt;
  logic [BIN_W-1:0]         bin;
  logic [BCD_W-1:0]         bcd;
  logic [BCD_W-1:0]         bcd_adj;
  logic [NUM_DIGITS-1:0]    blank_next;

  assign tick  = (cnt == '0) & ~freeze;
  assign start = (state == IDLE) & (tick | req | pending);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (.din(bcd[4*g +: 4]), .dout(bcd_adj[4*g +: 4]));
  end

  always_comb begin
    blank_next = '0;
`ifdef PERF_DISP_LZ_BLANK_EN
    begin
      logic lz;
      lz = 1'b1;
      // The ones digit is never blanked so zero still shows a single "0".
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        lz = lz & (bcd[4*i +: 4] == 4'd0);
        blank_next[i] = lz;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      ovf_next <= 1'b0;
      sh_cnt   <= '0;
      bin      <= '0;
      bcd      <= '0;
      digits   <= '0;
      blank    <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      upd      <= 1'b0;
    end else begin
      upd <= 1'b0;
      // A request landing on the start edge is served by that conversion.
      if (start)    pending <= 1'b0;
      else if (req) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            if (perf > MAX_DISP) begin
              bin      <= MAX_BIN;
              ovf_next <= 1'b1;
            end else begin
              bin      <= perf[BIN_W-1:0];
              ovf_next <= 1'b0;
            end
            bcd    <= '0;
            sh_cnt <= 5'd20;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj[BCD_W-2:0], bin, 1'b0};
          sh_cnt     <= sh_cnt - 5'd1;
          if (sh_cnt == 5'd1) state <= DONE;
        end
        DONE: begin
          digits <= bcd;
          ovf    <= ovf_next;
          blank  <= blank_next;
          upd    <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_perf_display_ctrl.sv
// Directed and randomized checks of perf_display_ctrl against a decimal-arithmetic reference.
module tb_perf_display_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] perf;
  logic        req;
  logic        freeze;
  logic [23:0] digits;
  logic [5:0]  blank;
  logic        ovf;
  logic        busy;
  logic        upd;

  int n_pass  = 0;
  int n_total = 0;
  int n_upd   = 0;
  int edges   = 0;

  perf_display_ctrl #(.REFRESH_LOG2(5), .NUM_DIGITS(6)) dut (
    .clk(clk), .rst(rst), .perf(perf), .req(req), .freeze(freeze),
    .digits(digits), .blank(blank), .ovf(ovf), .busy(busy), .upd(upd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (upd === 1'b1) n_upd++;
  end

  // Mirrors the refresh timer phase: value at a negedge equals edges mod 32.
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] clamp(input logic [31:0] p);
    return (p > 32'd999999) ? 32'd999999 : p;
  endfunction

  function automatic logic [23:0] exp_digits(input logic [31:0] p);
    logic [31:0] v;
    logic [23:0] d;
    v = clamp(p);
    d = '0;
    for (int i = 0; i < 6; i++) begin
      d[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return d;
  endfunction

  function automatic logic [5:0] exp_blank(input logic [31:0] p);
    logic [5:0]  b;
    logic [31:0] p10;
    b   = '0;
    p10 = 32'd1;
    for (int i = 1; i < 6; i++) begin
      p10 = p10 * 10;
`ifdef PERF_DISP_LZ_BLANK_EN
      b[i] = (clamp(p) < p10);
`endif
    end
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [31:0] p);
    check({tag, "_digits"}, 32'(digits), 32'(exp_digits(p)));
    check({tag, "_ovf"},    32'(ovf),    32'(p > 32'd999999));
    check({tag, "_blank"},  32'(blank),  32'(exp_blank(p)));
  endtask

  task automatic wait_upd(input int maxc, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (upd === 1'b1) break;
      if (cyc >= maxc) begin
        check("upd_timeout", 32'(upd), 32'd1);
        break;
      end
    end
  endtask

  task automatic pulse_req();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    int cyc;
    int n0;
    logic [31:0] pa, pc;

    rst = 1'b0; perf = 32'd123456; req = 1'b0; freeze = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_digits", 32'(digits), 32'd0);
    check("rst_blank",  32'(blank),  32'd0);
    check("rst_ovf",    32'(ovf),    32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_upd",    32'(upd),    32'd0);

    // First tick lands on the first edge after release.
    rst = 1'b1;
    @(negedge clk);
    check("t1_busy", 32'(busy), 32'd1);
    wait_upd(40, cyc);
    check("t1_latency", 32'(cyc), 32'd21);
    check_out("t1", 32'd123456);
    @(negedge clk);
    check("t1_upd_single", 32'(upd), 32'd0);

    perf = 32'hFFFF_FFFF;
    wait_upd(40, cyc);
    check_out("max", 32'hFFFF_FFFF);
    perf = 32'd7;
    wait_upd(40, cyc);
    check_out("seven", 32'd7);
    perf = 32'd0;
    wait_upd(40, cyc);
    check_out("zero", 32'd0);

    freeze = 1'b1;
    perf = 32'd42;
    n0 = n_upd;
    repeat (100) @(negedge clk);
    check("frz_no_upd", 32'(n_upd - n0), 32'd0);
    pulse_req();
    wait_upd(40, cyc);
    check("frz_req_latency", 32'(cyc), 32'd21);
    check_out("frz_req", 32'd42);
    n0 = n_upd;
    repeat (100) @(negedge clk);
    check("frz_quiet", 32'(n_upd - n0), 32'd0);

    // Request during a conversion queues exactly one more.
    pa = $urandom_range(0, 999999);
    perf = pa;
    pulse_req();
    repeat (4) @(negedge clk);
    req = 1'b1;
    perf = $urandom;
    @(negedge clk);
    req = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_hold", 32'(digits), 32'(exp_digits(32'd42)));
    wait_upd(40, cyc);
    check_out("mid_first", pa);
    pc = $urandom;
    perf = pc;
    wait_upd(40, cyc);
    check("mid_second_latency", 32'(cyc), 32'd22);
    check_out("mid_second", pc);
    n0 = n_upd;
    repeat (60) @(negedge clk);
    check("mid_no_third", 32'(n_upd - n0), 32'd0);

    // Tick and req on the same edge produce a single conversion.
    perf = $urandom_range(0, 999999);
    freeze = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (edges % 32 == 0) break;
    end
    n0 = n_upd;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    freeze = 1'b1;
    repeat (60) @(negedge clk);
    check("tick_req_once", 32'(n_upd - n0), 32'd1);
    check_out("tick_req", perf);

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0: perf = $urandom;
        1: perf = $urandom_range(0, 999999);
        2: perf = $urandom_range(0, 99);
        default: perf = $urandom_range(999990, 1000010);
      endcase
      pulse_req();
      wait_upd(40, cyc);
      check_out("rand", perf);
    end

    perf = 32'd999999;
    pulse_req();
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_digits", 32'(digits), 32'd0);
    check("arst_blank",  32'(blank),  32'd0);
    check("arst_ovf",    32'(ovf),    32'd0);
    check("arst_busy",   32'(busy),   32'd0);
    check("arst_upd",    32'(upd),    32'd0);
    @(negedge clk);
    freeze = 1'b0;
    rst = 1'b1;
    wait_upd(40, cyc);
    check("arst_latency", 32'(cyc), 32'd22);
    check_out("arst", 32'd999999);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
